// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// Holds the FSM state type, frame sizes and the baud divider helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    function automatic int calc_div(input int clk_freq, input int baudrate);
        return clk_freq / baudrate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO queueing bytes for the UART transmitter.
// Depth must be a power of two so the pointers wrap naturally.
module uart_tx_fifo #(
    parameter int depth = 4,
    parameter int width = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [width-1:0]       wdata,
    output logic [width-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(depth):0] count
);

    localparam int AW = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(depth));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of the shifter.
// Frames are sent LSB first, back to back while the FIFO holds data.
module uart_tx
    import uart_pkg::*;
#(
    parameter int clk_freq   = 16000000,
    parameter int baudrate   = 115200,
    parameter int fifo_depth = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        TX,
    output logic                        busy,
    output logic [$clog2(fifo_depth):0] fifo_count
);

    localparam int DIV = calc_div(clk_freq, baudrate);
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    if (DIV < 2) begin : g_div_check
        $error("uart_tx: clk_freq/baudrate must be at least 2");
    end

    state_t     state;
    logic [CW-1:0] baud;
    logic [2:0] bit_idx;
    logic [7:0] shift;
    logic [7:0] head;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic       baud_done;

    assign tx_ready  = !full;
    assign push      = tx_valid && tx_ready;
    assign baud_done = (baud == '0);
    // Pop when idle, or on the last stop-bit clock for a zero-gap restart.
    assign pop       = !empty && ((state == IDLE) ||
                                  (state == STOP && baud_done));
    assign busy      = (state != IDLE) || (fifo_count != '0);

    uart_tx_fifo #(
        .depth (fifo_depth),
        .width (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (tx_data),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            TX      <= 1'b1;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        shift   <= head;
                        bit_idx <= '0;
                        baud    <= LAST;
                        TX      <= 1'b0;
                        state   <= START;
                    end else begin
                        TX <= 1'b1;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud  <= LAST;
                        TX    <= shift[0];
                        state <= DATA;
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud <= LAST;
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            TX    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= shift >> 1;
                            TX      <= shift[1];
                        end
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        if (pop) begin
                            shift   <= head;
                            bit_idx <= '0;
                            baud    <= LAST;
                            TX      <= 1'b0;
                            state   <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    TX    <= 1'b1;
                end
            endcase
        end
    end

endmodule
